// File: rtl/mips_dmem_wait_bridge_pkg.sv
// Shared encodings for the MIPS data-memory wait-state bridge.
// Access sizes, FSM state codes and lane count.
package mips_dmem_wait_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int LANES = 4;

endpackage

// File: rtl/mips_dmem_wait_bridge_lane_unit.sv
// Byte-lane steering: store enables/replication and load extract/extend.
// Purely combinational so an on-chip memory path can reuse it.
module mips_dmem_lane_unit
    import mips_dmem_wait_bridge_pkg::*;
(
    input  logic [1:0]       st_size,
    input  logic [1:0]       st_off,
    input  logic [31:0]      st_wdata,
    output logic [LANES-1:0] st_be,
    output logic [31:0]      st_wdata_rep,
    output logic             st_misaligned,
    input  logic [1:0]       ld_size,
    input  logic [1:0]       ld_off,
    input  logic             ld_signed,
    input  logic [31:0]      ld_rdata,
    output logic [31:0]      ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_be         = 4'b1111;
        st_wdata_rep  = st_wdata;
        st_misaligned = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                st_be        = 4'b0001 << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be         = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep  = {2{st_wdata[15:0]}};
                st_misaligned = st_off[0];
            end
            default: st_misaligned = |st_off;
        endcase
    end

    // Halfword offsets reaching here are always even.
    always_comb begin
        shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mips_dmem_wait_bridge.sv
// Stalls the single-cycle core across a variable-latency req/ack data memory,
// with sub-word access, misalignment trapping and a bus timeout.
module mips_dmem_wait_bridge
    import mips_dmem_wait_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_signed,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [LANES-1:0]      mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [LANES-1:0]      mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         tmo_q, tmo_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic                  sgn_q, sgn_d;

    logic [LANES-1:0]      st_be;
    logic [DATA_WIDTH-1:0] st_wrep;
    logic                  st_mis;
    logic [DATA_WIDTH-1:0] ld_data;

    mips_dmem_lane_unit u_lane (
        .st_size      (cpu_size),
        .st_off       (cpu_addr[1:0]),
        .st_wdata     (cpu_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wrep),
        .st_misaligned(st_mis),
        .ld_size      (size_q),
        .ld_off       (off_q),
        .ld_signed    (sgn_q),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        size_d      = size_q;
        off_d       = off_q;
        sgn_d       = sgn_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && st_mis) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else if (cpu_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_be_d    = st_be;
                    mem_addr_d  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata_d = st_wrep;
                    size_d      = cpu_size;
                    off_d       = cpu_addr[1:0];
                    sgn_d       = cpu_signed;
                    tmo_d       = '0;
                    state_d     = ST_BUSY;
                end
            end
            // An ack on the final allowed cycle beats the timeout.
            ST_BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    rdata_d   = mem_we_q ? '0 : ld_data;
                    state_d   = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    state_d   = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            sgn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sgn_q       <= sgn_d;
        end
    end

    assign cpu_stall = ((state_q == ST_IDLE) && cpu_req) || (state_q == ST_BUSY);
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips_dmem_wait_bridge.sv
// Scoreboard bench: driver queues expectations, monitors compare on
// completion and on every cycle the external request is live.
module tb_mips_dmem_wait_bridge;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cpu_req, cpu_we, cpu_signed;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    mips_dmem_wait_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    typedef struct {
        int          lat;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];

    int   checks = 0;
    int   fails  = 0;
    logic model_err = 1'b0;
    logic mon_en = 1'b1;
    logic force_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] sz, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
        int n;
        logic [63:0] v;
        logic [63:0] one;
        n = nbytes(sz);
        if (n == 4) return rd;
        one = 64'd1;
        v = {32'd0, rd} >> (8 * (a % 4));
        v = v % (one << (8 * n));
        if (sgn && v >= (one << (8 * n - 1)))
            v = v + 64'h1_0000_0000 - (one << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        int n;
        int m;
        n = nbytes(sz);
        m = ((1 << n) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
        int n;
        n = nbytes(sz);
        if (n == 1) return {24'd0, w[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'd0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    // Completion monitor
    int stall_cnt = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (!mon_en) begin
            stall_cnt = 0;
        end else if (cpu_req && cpu_stall) begin
            stall_cnt++;
        end else if (cpu_req) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("cpu_rdata", cpu_rdata, e.rdata);
                chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
                chk("stall_cycles", stall_cnt, e.stalls);
            end
            stall_cnt = 0;
        end
    end

    // Memory responder and bus-side monitor
    int    busy_cnt = 0;
    plan_t cur;
    always @(negedge CLK) begin
        if (!mem_req) begin
            busy_cnt  = 0;
            mem_ack   <= force_ack | ($urandom_range(0, 5) == 0);
            mem_rdata <= $urandom;
        end else begin
            if (busy_cnt == 0) begin
                if (plan_q.size() == 0) begin
                    chk("mem_req_unplanned", 32'd1, 32'd0);
                    cur.lat = 1; cur.we = mem_we; cur.be = mem_be;
                    cur.addr = mem_addr; cur.wdata = mem_wdata; cur.rdata = '0;
                end else begin
                    cur = plan_q.pop_front();
                end
            end
            busy_cnt++;
            chk("busy_len", {31'd0, busy_cnt <= ((cur.lat == 0) ? TO : cur.lat)}, 32'd1);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
            chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            if (cur.lat != 0 && busy_cnt == cur.lat) begin
                mem_ack   <= 1'b1;
                mem_rdata <= cur.rdata;
            end else begin
                mem_ack   <= 1'b0;
                mem_rdata <= $urandom;
            end
        end
    end

    task automatic do_access(input logic we, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int lat);
        exp_t  e;
        plan_t p;
        bit    done;
        @(posedge CLK);
        #1;
        cpu_we = we; cpu_size = sz; cpu_signed = sgn;
        cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        if (misal(sz, a)) begin
            model_err = 1'b1;
            e.rdata = '0;
            e.stalls = 1;
        end else begin
            p.lat = lat; p.we = we; p.be = exp_be(sz, a);
            p.addr = a - (a % 4); p.wdata = exp_wd(sz, wd); p.rdata = rd;
            plan_q.push_back(p);
            if (lat == 0) begin
                model_err = 1'b1;
                e.rdata = '0;
                e.stalls = TO + 1;
            end else begin
                e.rdata = we ? 32'd0 : load_val(sz, sgn, a, rd);
                e.stalls = lat + 1;
            end
        end
        e.err = model_err;
        exp_q.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge CLK);
            if (!cpu_stall) done = 1'b1;
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        @(posedge CLK);
        #1;
        cpu_req = 1'b0;
        cpu_addr = $urandom;
        repeat (n - 1) @(posedge CLK);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        plan_t       p;
        RST_N = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_signed = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        #3;
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_err", {31'd0, cpu_err}, 32'd0);
        cpu_req = 1'b1;
        #1;
        chk("rst_stall_req", {31'd0, cpu_stall}, 32'd1);
        cpu_req = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        do_access(1'b0, 2'b10, 1'b0, 32'h10, $urandom, 32'hDEAD_BEEF, 3);
        do_access(1'b0, 2'b00, 1'b1, 32'h13, $urandom, 32'h80FF_0000, 2);
        do_access(1'b0, 2'b00, 1'b0, 32'h13, $urandom, 32'h80FF_0000, 1);
        do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_ABCD, $urandom, 2);
        do_access(1'b0, 2'b11, 1'b1, 32'h5C, $urandom, 32'h8000_0001, TO);
        idle_cycles(2);
        do_access(1'b0, 2'b10, 1'b0, 32'h06, $urandom, $urandom, 1);
        do_access(1'b0, 2'b10, 1'b0, 32'h44, $urandom, $urandom, 0);
        do_access(1'b0, 2'b10, 1'b0, 32'h48, $urandom, 32'h0BAD_F00D, 1);

        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
            end
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                      a, $urandom, $urandom, $urandom_range(0, TO));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(2);
        mon_en = 1'b0;
        @(posedge CLK);
        #1;
        cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h80; cpu_req = 1'b1;
        p.lat = 0; p.we = 1'b0; p.be = 4'hF; p.addr = 32'h80;
        p.wdata = '0; p.rdata = '0;
        plan_q.push_back(p);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        chk("busy_before_rst", {31'd0, mem_req}, 32'd1);
        RST_N = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_async_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_async_err", {31'd0, cpu_err}, 32'd0);
        model_err = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        force_ack = 1'b1;
        @(posedge CLK);
        #1;
        force_ack = 1'b0;
        chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, cpu_stall}, 32'd0);
        mon_en = 1'b1;
        do_access(1'b0, 2'b01, 1'b1, 32'h32, $urandom, 32'h8001_1234, 2);
        do_access(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00A5, $urandom, 1);

        idle_cycles(3);
        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("plan_q_empty", plan_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
